// File: rtl/loader_byte_fifo_pkg.sv
// Shared types and widths for the loader byte FIFO.
package loader_byte_fifo_pkg;

    localparam int BYTE_TOTAL_W = 25;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/system_consts.sv
// System-wide sizing constants shared across the loader path.
// Loader FIFO sizing: DEPTH entries, in_wait raised at AFULL to absorb in-flight strobes.
package system_consts;

    localparam int LOADER_FIFO_DEPTH = 16;
    localparam int LOADER_FIFO_AFULL = 12;

endpackage

// File: rtl/loader_byte_fifo.sv
// Byte FIFO between ddr_rom_loader_adaptor and rom_loader, paced by a 3-state pop FSM.
// Latency: push on edge ending cycle N into an empty FIFO gives out_wr in cycle N+2; out_wr pulses at least 3 cycles apart.
// Backpressure: in_wait = (count >= AFULL); a pop is only launched from IDLE while out_wait is low.
module loader_byte_fifo
    import system_consts::*;
    import loader_byte_fifo_pkg::*;
#(
    parameter int DEPTH = LOADER_FIFO_DEPTH,
    parameter int AFULL = LOADER_FIFO_AFULL
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_strobe,
    input  logic [7:0]                in_data,
    output logic                      in_wait,
    output logic                      out_wr,
    output logic [7:0]                out_data,
    input  logic                      out_wait,
    output logic [$clog2(DEPTH):0]    count,
    output logic [BYTE_TOTAL_W-1:0]   byte_total,
    output logic                      overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [BYTE_TOTAL_W-1:0]  byte_total_q, byte_total_d;
    logic                     overflow_q, overflow_d;
    byte_t                    out_data_q, out_data_d;
    byte_t                    mem_q [DEPTH];

    logic push;
    logic drop;
    logic pop;
    logic not_empty;
    logic full;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH_C);

    // Flush outranks a same-cycle strobe: the byte is discarded without flagging overflow.
    assign push = in_strobe && !flush && !full;
    assign drop = in_strobe && !flush && full;

    // ---------------- pop FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- pop FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (not_empty && !out_wait) state_d = ST_STROBE;
                ST_STROBE: state_d = ST_SETTLE;
                ST_SETTLE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- pop FSM: outputs ----------------
    always_comb begin
        pop    = 1'b0;
        out_wr = 1'b0;
        case (state_q)
            ST_IDLE:   pop    = not_empty && !out_wait && !flush;
            ST_STROBE: out_wr = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        byte_total_d = byte_total_q;
        overflow_d   = overflow_q;
        out_data_d   = out_data_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            byte_total_d = '0;
            overflow_d   = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // out_data is captured at pop time and held until the next pop.
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                out_data_d   = mem_q[rd_ptr_q];
                byte_total_d = byte_total_q + 1'b1;
            end
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_total_q <= '0;
            overflow_q   <= 1'b0;
            out_data_q   <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_total_q <= byte_total_d;
            overflow_q   <= overflow_d;
            out_data_q   <= out_data_d;
        end
    end

    // Storage needs no reset; occupancy tracking alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_wait    = (count_q >= AFULL_C);
    assign count      = count_q;
    assign byte_total = byte_total_q;
    assign overflow   = overflow_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_loader_byte_fifo.sv
// Scoreboard bench for loader_byte_fifo: bytes queued on accepted strobes, popped on out_wr.
module tb_loader_byte_fifo;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_strobe;
    logic [7:0]  in_data;
    logic        in_wait;
    logic        out_wr;
    logic [7:0]  out_data;
    logic        out_wait;
    logic [4:0]  count;
    logic [24:0] byte_total;
    logic        overflow;

    logic        hold_wait;
    logic        sdr_mode;
    int          sdr_cnt;

    logic [7:0]  sb[$];
    int          wr_times[$];
    int          cyc;
    int          n_wr;
    int          checks;
    int          errors;
    logic        prev_wait;

    loader_byte_fifo dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_strobe  (in_strobe),
        .in_data    (in_data),
        .in_wait    (in_wait),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .out_wait   (out_wait),
        .count      (count),
        .byte_total (byte_total),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // rom_loader SDR model: out_wait held high for 5 cycles after every out_wr.
    assign out_wait = sdr_mode ? (sdr_cnt != 0) : hold_wait;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          sdr_cnt <= 0;
        else if (out_wr)       sdr_cnt <= 5;
        else if (sdr_cnt != 0) sdr_cnt <= sdr_cnt - 1;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && out_wr) begin
            wr_times.push_back(cyc);
            n_wr++;
            chk_val("wr_while_wait", {31'd0, prev_wait}, 32'd0);
            if (sb.size() == 0) chk_val("wr_unexpected", 32'(sb.size() != 0), 32'd1);
            else                chk_val("wr_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
        prev_wait = out_wait;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit accept);
        in_strobe = 1'b1;
        in_data   = d;
        if (accept) sb.push_back(d);
        @(posedge clk);
        #1;
        in_strobe = 1'b0;
    endtask

    task automatic wait_wr(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (out_wr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int k;
        int nw;
        int g;
        cyc = 0; n_wr = 0; checks = 0; errors = 0; prev_wait = 1'b0;
        reset_n = 1'b0; flush = 1'b0; in_strobe = 1'b0; in_data = 8'h00;
        hold_wait = 1'b0; sdr_mode = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("rst_out_wr",     {31'd0, out_wr},   32'd0);
        chk_val("rst_out_data",   {24'd0, out_data}, 32'd0);
        chk_val("rst_count",      {27'd0, count},    32'd0);
        chk_val("rst_byte_total", {7'd0, byte_total}, 32'd0);
        chk_val("rst_overflow",   {31'd0, overflow}, 32'd0);
        chk_val("rst_in_wait",    {31'd0, in_wait},  32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(2);

        // Three back-to-back bytes: out_wr at cycles 2,5,8 relative to the first strobe
        wr_times.delete();
        k = cyc;
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        tick(12);
        chk_val("t1_wr_cnt", wr_times.size(), 3);
        for (int i = 0; i < 3 && i < wr_times.size(); i++)
            chk_val($sformatf("t1_wr_cycle%0d", i), wr_times[i] - k, 2 + 3 * i);
        chk_val("t1_byte_total", {7'd0, byte_total}, 32'd3);
        chk_val("t1_count",      {27'd0, count},     32'd0);

        // Fill with out_wait held: in_wait at 12, full at 16, 17th dropped
        hold_wait = 1'b1;
        tick(1);
        nw = n_wr;
        for (int i = 0; i < 11; i++) send(8'h40 + 8'(i), 1'b1);
        chk_val("t2_count11",   {27'd0, count},   32'd11);
        chk_val("t2_in_wait11", {31'd0, in_wait}, 32'd0);
        send(8'h4B, 1'b1);
        chk_val("t2_count12",   {27'd0, count},   32'd12);
        chk_val("t2_in_wait12", {31'd0, in_wait}, 32'd1);
        for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b1);
        chk_val("t2_count16",    {27'd0, count},    32'd16);
        chk_val("t2_ovf_before", {31'd0, overflow}, 32'd0);
        send(8'hEE, 1'b0);
        chk_val("t2_overflow",  {31'd0, overflow}, 32'd1);
        chk_val("t2_count_17",  {27'd0, count},    32'd16);
        tick(3);
        chk_val("t2_no_wr", n_wr - nw, 0);

        // Drain 16: exact 3-cycle spacing, in_wait falls below 12
        wr_times.delete();
        hold_wait = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            wait_wr(20, ok);
            chk_val("t3_wr_seen", {31'd0, ok}, 32'd1);
            chk_val("t3_count",   {27'd0, count},   32'(16 - j));
            chk_val("t3_in_wait", {31'd0, in_wait}, 32'((16 - j) >= 12));
        end
        @(posedge clk);
        #1;
        for (int i = 1; i < wr_times.size(); i++)
            chk_val("t3_gap", wr_times[i] - wr_times[i-1], 3);
        chk_val("t3_sb_empty",   sb.size(),          0);
        chk_val("t3_byte_total", {7'd0, byte_total}, 32'd19);

        // 1000 random bytes against the SDR out_wait model
        sdr_mode = 1'b1;
        nw = n_wr;
        for (int i = 0; i < 1000; i++) begin
            g = 0;
            while (in_wait && g < 200) begin
                tick(1);
                g++;
            end
            if (g >= 200) chk_val("t4_in_wait_stuck", {31'd0, in_wait}, 32'd0);
            send(8'($urandom), 1'b1);
            if ($urandom_range(3) == 0) tick($urandom_range(3));
        end
        g = 0;
        while (sb.size() != 0 && g < 20000) begin
            tick(1);
            g++;
        end
        chk_val("t4_drain", sb.size(), 0);
        tick(10);
        chk_val("t4_wr_cnt",     n_wr - nw,          1000);
        chk_val("t4_byte_total", {7'd0, byte_total}, 32'd1019);
        sdr_mode = 1'b0;
        tick(2);

        // Flush with concurrent strobe at count=5, overflow=1
        hold_wait = 1'b1;
        tick(1);
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b1);
        send(8'hEE, 1'b0);
        chk_val("t5_ovf_set", {31'd0, overflow}, 32'd1);
        hold_wait = 1'b0;
        for (int j = 0; j < 11; j++) begin
            wait_wr(20, ok);
            chk_val("t5_wr_seen", {31'd0, ok}, 32'd1);
        end
        hold_wait = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        chk_val("t5_count5",  {27'd0, count},    32'd5);
        chk_val("t5_ovf_pre", {31'd0, overflow}, 32'd1);
        nw = n_wr;
        flush = 1'b1; in_strobe = 1'b1; in_data = 8'h77;
        sb.delete();
        @(posedge clk);
        #1;
        flush = 1'b0; in_strobe = 1'b0;
        chk_val("t5_count",      {27'd0, count},      32'd0);
        chk_val("t5_overflow",   {31'd0, overflow},   32'd0);
        chk_val("t5_byte_total", {7'd0, byte_total},  32'd0);
        chk_val("t5_out_wr",     {31'd0, out_wr},     32'd0);
        chk_val("t5_in_wait",    {31'd0, in_wait},    32'd0);
        hold_wait = 1'b0;
        tick(10);
        chk_val("t5_no_wr", n_wr - nw, 0);

        // Reset asserted during STROBE, then a single byte after release
        send(8'h3C, 1'b1);
        wait_wr(10, ok);
        chk_val("t6_wr_seen", {31'd0, ok}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_val("t6_async_wr",   {31'd0, out_wr},    32'd0);
        chk_val("t6_rst_count",  {27'd0, count},     32'd0);
        chk_val("t6_rst_total",  {7'd0, byte_total}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(2);
        nw = n_wr;
        send(8'hA5, 1'b1);
        tick(10);
        chk_val("t6_wr_cnt",     n_wr - nw,          1);
        chk_val("t6_byte_total", {7'd0, byte_total}, 32'd1);
        chk_val("t6_sb_empty",   sb.size(),          0);
        chk_val("t6_out_data",   {24'd0, out_data},  32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loader_byte_fifo.md
LOADER_BYTE_FIFO -- requirements
Module: loader_byte_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two).
REQ-002 SHALL have parameter AFULL, default 12, occupancy at which in_wait asserts.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear, pulsed at start of each download.
REQ-006 SHALL have port in_strobe  input  1  upstream byte valid, one-cycle pulse (ddr_rom_loader_adaptor data_strobe).
REQ-007 SHALL have port in_data  input  8  upstream byte.
REQ-008 SHALL have port in_wait  output  1  upstream backpressure (drives adaptor data_wait).
REQ-009 SHALL have port out_wr  output  1  downstream byte strobe (rom_loader ioctl_wr).
REQ-010 SHALL have port out_data  output  8  downstream byte (rom_loader ioctl_data).
REQ-011 SHALL have port out_wait  input  1  downstream backpressure (rom_loader ioctl_wait).
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port byte_total  output  25  bytes delivered downstream since last flush/reset.
REQ-014 SHALL have port overflow  output  1  sticky: byte dropped while full.

Function
REQ-015 SHALL push in_data when in_strobe=1 and count<DEPTH; write pointer increments modulo DEPTH.
REQ-016 SHALL drop the byte and set overflow when in_strobe=1 and count=DEPTH; count and pointers unchanged.
REQ-017 SHALL drive in_wait combinationally as (count>=AFULL); DEPTH-AFULL entries absorb upstream in-flight strobes.
REQ-018 SHALL implement pop FSM with states IDLE, STROBE, SETTLE.
REQ-019 IDLE: if count>0 and out_wait=0, SHALL register out_data from read pointer, set out_wr=1, pop (read pointer +1 mod DEPTH), go STROBE.
REQ-020 STROBE: out_wr=1 for exactly this one cycle; next state SETTLE, out_wr=0.
REQ-021 SETTLE: one cycle, out_wr=0, lets the registered out_wait settle; next state IDLE.
REQ-022 Consequence: minimum 3 cycles between out_wr pulses; no out_wr ever issued while out_wait=1 is sampled in IDLE.
REQ-023 out_data SHALL stay stable from the out_wr cycle until the next pop.
REQ-024 Latency: byte pushed on edge ending cycle N into empty FIFO, out_wait=0 -> out_wr=1 in cycle N+2.
REQ-025 Simultaneous push and pop in one cycle SHALL leave count unchanged; pop of the last entry with concurrent push SHALL be legal.
REQ-026 byte_total SHALL increment by 1 per out_wr, wrap modulo 2^25.
REQ-027 flush=1 SHALL clear pointers, count, byte_total, overflow, out_wr and return FSM to IDLE next cycle; flush wins over a simultaneous in_strobe (byte discarded, overflow not set).
REQ-028 flush during STROBE SHALL still terminate out_wr after the current cycle; no further pops until new data.

Reset
REQ-029 reset_n=0 SHALL asynchronously force: FSM IDLE, pointers 0, count 0, out_wr 0, out_data 8'h00, byte_total 0, overflow 0; in_wait therefore 0.
REQ-030 Deassertion of reset_n mid-transfer SHALL discard FIFO contents; first legal out_wr no earlier than 2 cycles after first push post-reset.
REQ-031 Storage array contents need not be reset.

Structure
REQ-032 LOADER_FIFO_DEPTH (16) and LOADER_FIFO_AFULL (12) SHALL live in system_consts; FSM state enum stays local.
REQ-033 Storage SHALL be an in-module register array; no sub-module.
REQ-034 Intended placement: between ddr_rom_loader_adaptor (data_*) and rom_loader (ioctl_*), same clock domain.

Verification
REQ-035 Push 0x11,0x22,0x33 on consecutive cycles, out_wait=0 -> out_wr at cycles 2,5,8 with data 11,22,33; byte_total=3; count returns 0.
REQ-036 Hold out_wait=1, push 12 bytes -> in_wait=1 when count reaches 12; 4 more pushes accepted (count=16); 17th push -> overflow=1, count stays 16, no out_wr.
REQ-037 Release out_wait with 16 bytes queued -> 16 out_wr pulses, exactly 3 cycles apart, data order preserved, in_wait drops when count<12.
REQ-038 out_wait asserted in cycle after each out_wr for 5 cycles (rom_loader SDR model) -> no out_wr while out_wait=1, no lost or duplicated bytes over 1000 random bytes.
REQ-039 Assert flush together with in_strobe while count=5, overflow=1 -> next cycle count=0, overflow=0, byte_total=0, out_wr=0.
REQ-040 Pull reset_n low during STROBE -> out_wr drops asynchronously; after release, push 0xA5 -> single out_wr with 0xA5, byte_total=1.
